// File: rtl/nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : nibble_serial_adder (plus helper ripple_carry_adder_4bit)
// Description : Multi-cycle wide-operand adder. Latches A, B and carry-in on
//               an accepted start, then streams LSB-first nibbles through a
//               single 4-bit ripple-carry adder, one nibble per cycle, with
//               the carry held in a register between nibbles.
//               {c_out, sum} = A + B + c_in, W = 4*NIBBLES.
// Parameters  : NIBBLES - operand width in nibbles, legal range 2..8.
// Ports       : clk    - clock, all state changes on rising edge
//               rst    - synchronous active-high reset
//               start  - request, sampled only when not busy
//               a, b   - W-bit operands, sampled with accepted start
//               c_in   - carry-in, sampled with accepted start
//               busy   - high during the NIBBLES processing cycles
//               done   - one-cycle pulse when sum/c_out update
//               sum    - registered result, held until next done
//               c_out  - registered final carry, held with sum
//               ovf    - signed overflow (only with NIBBLE_ADDER_OVF_EN)
// Options     : NIBBLE_ADDER_OVF_EN - adds the registered ovf output.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// 4-bit ripple-carry adder: a + b + c_in -> {c_out, sum}. Purely combinational.
// ----------------------------------------------------------------------------
module ripple_carry_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);

    logic [4:0] w_c;

    assign w_c[0] = c_in;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign c_out = w_c[4];

endmodule

// ----------------------------------------------------------------------------
// Top level
// ----------------------------------------------------------------------------
module nibble_serial_adder #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   a,
    input  logic [4*NIBBLES-1:0]   b,
    input  logic                   c_in,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   sum,
    output logic                   c_out
`ifdef NIBBLE_ADDER_OVF_EN
    ,
    output logic                   ovf
`endif
);

    localparam int              c_w    = 4 * NIBBLES;
    localparam int              c_cw   = $clog2(NIBBLES);
    localparam logic [c_cw-1:0] c_last = c_cw'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [c_w-1:0]  r_a;
    logic [c_w-1:0]  r_b;
    logic            r_carry;
    logic [c_cw-1:0] r_cnt;
    logic [3:0]      r_acc [NIBBLES];

    logic [3:0]      w_a_nibs [NIBBLES];
    logic [3:0]      w_b_nibs [NIBBLES];
    logic [3:0]      w_a_nib;
    logic [3:0]      w_b_nib;
    logic [3:0]      w_nsum;
    logic            w_ncout;
    logic [c_w-1:0]  w_acc_final;
    logic            w_accept;

    // Split latched operands into nibbles so the active one can be selected
    // by the counter. The final-result view merges the nibble being written
    // this cycle with the ones already in the accumulator, because the last
    // adder output lands in sum on the same edge that enters DONE.
    for (genvar i = 0; i < NIBBLES; i++) begin : g_nib
        localparam logic [c_cw-1:0] c_idx = c_cw'(i);
        assign w_a_nibs[i]          = r_a[4*i +: 4];
        assign w_b_nibs[i]          = r_b[4*i +: 4];
        assign w_acc_final[4*i +: 4] = (r_cnt == c_idx) ? w_nsum : r_acc[i];
    end

    assign w_a_nib = w_a_nibs[r_cnt];
    assign w_b_nib = w_b_nibs[r_cnt];

    ripple_carry_adder_4bit u_rca (
        .a     (w_a_nib),
        .b     (w_b_nib),
        .c_in  (r_carry),
        .sum   (w_nsum),
        .c_out (w_ncout)
    );

    // New work is taken only when not busy; DONE accepts for back-to-back.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            for (int i = 0; i < NIBBLES; i++) begin
                r_acc[i] <= 4'h0;
            end
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
`ifdef NIBBLE_ADDER_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= c_in;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    r_acc[r_cnt] <= w_nsum;
                    r_carry      <= w_ncout;
                    if (r_cnt == c_last) begin
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        sum     <= w_acc_final;
                        c_out   <= w_ncout;
`ifdef NIBBLE_ADDER_OVF_EN
                        // Top nibble's sum bit 3 is the result sign bit.
                        ovf     <= (r_a[c_w-1] == r_b[c_w-1]) &&
                                   (w_nsum[3] != r_a[c_w-1]);
`endif
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_nibble_serial_adder
// Description : Self-checking bench for nibble_serial_adder, NIBBLES=4.
//               Directed vector table, hand-written multi-cycle sequences
//               (start while busy, back-to-back, reset mid-run) and random
//               operations checked against an arithmetic reference model.
//               Build with NIBBLE_ADDER_OVF_EN to also check ovf.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder;

    localparam int c_n = 4;
    localparam int c_w = 4 * c_n;

    logic           clk;
    logic           rst;
    logic           start;
    logic [c_w-1:0] a;
    logic [c_w-1:0] b;
    logic           c_in;
    logic           busy;
    logic           done;
    logic [c_w-1:0] sum;
    logic           c_out;
    logic           ovf;

    int n_checks;
    int n_errors;

    nibble_serial_adder #(.NIBBLES(c_n)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out)
`ifdef NIBBLE_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

`ifndef NIBBLE_ADDER_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [c_w-1:0] a;
        logic [c_w-1:0] b;
        logic           cin;
        logic [c_w-1:0] exp_sum;
        logic           exp_cout;
    } vec_t;

    vec_t vecs [6];

    // Advance one clock; leave the bench 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic plus the signed-overflow rule.
    function automatic logic [c_w:0] model_add(input logic [c_w-1:0] x,
                                               input logic [c_w-1:0] y,
                                               input logic ci);
        return {1'b0, x} + {1'b0, y} + {{c_w{1'b0}}, ci};
    endfunction

    function automatic logic model_ovf(input logic [c_w-1:0] x,
                                       input logic [c_w-1:0] y,
                                       input logic [c_w-1:0] s);
        return (x[c_w-1] == y[c_w-1]) && (s[c_w-1] != x[c_w-1]);
    endfunction

    task automatic check_result(input string name, input logic [c_w-1:0] x,
                                input logic [c_w-1:0] y,
                                input logic [c_w-1:0] es, input logic ec);
        check({name, ".done"}, 32'(done), 32'd1);
        check({name, ".sum"}, 32'(sum), 32'(es));
        check({name, ".c_out"}, 32'(c_out), 32'(ec));
`ifdef NIBBLE_ADDER_OVF_EN
        check({name, ".ovf"}, 32'(ovf), 32'(model_ovf(x, y, es)));
`endif
    endtask

    // One full operation from IDLE: accept, NIBBLES busy cycles, done pulse,
    // then done must drop again.
    task automatic run_op(input string name, input logic [c_w-1:0] x,
                          input logic [c_w-1:0] y, input logic ci,
                          input logic [c_w-1:0] es, input logic ec);
        a = x; b = y; c_in = ci; start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom; b = $urandom; c_in = 1'($urandom);
        for (int k = 0; k < c_n; k++) begin
            check({name, ".busy_run"}, 32'({busy, done}), 32'b10);
            tick();
        end
        check({name, ".busy_done"}, 32'(busy), 32'd0);
        check_result(name, x, y, es, ec);
        tick();
        check({name, ".pulse_end"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [c_w:0] ref_r;
        logic [c_w-1:0] ra;
        logic [c_w-1:0] rb;
        logic           rc;
        int             dones;

        n_checks = 0;
        n_errors = 0;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0};

        // Reset with start held high: start must be ignored.
        rst = 1'b1; start = 1'b1; a = 16'h1234; b = 16'h4321; c_in = 1'b1;
        tick();
        tick();
        rst = 1'b0; start = 1'b0;
        check("reset.outputs", 32'({busy, done, c_out, ovf, sum}), 32'd0);

        for (int i = 0; i < 10; i++) begin
            check("idle.busy_done", 32'({busy, done}), 32'd0);
            tick();
        end

        // Directed table.
        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].exp_sum, vecs[i].exp_cout);
        end

        // Start pulsed during RUN is ignored; a single done follows.
        a = 16'h0F0F; b = 16'h0101; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (i == 2) begin
                check_result("busy_start", 16'h0F0F, 16'h0101, 16'h1010, 1'b0);
            end
            if (done) dones++;
            tick();
        end
        check("busy_start.done_count", 32'(dones), 32'd1);

        // Back-to-back with start held high.
        a = 16'h0001; b = 16'h0001; c_in = 1'b0; start = 1'b1;
        tick();
        for (int k = 0; k < c_n; k++) tick();
        check_result("b2b.first", 16'h0001, 16'h0001, 16'h0002, 1'b0);
        a = 16'h8000; b = 16'h8000;
        tick();
        check("b2b.rerun_busy", 32'({busy, done}), 32'b10);
        for (int k = 0; k < c_n - 1; k++) tick();
        check("b2b.last_run_busy", 32'({busy, done}), 32'b10);
        tick();
        check_result("b2b.second", 16'h8000, 16'h8000, 16'h0000, 1'b1);
        start = 1'b0;
        tick();
        check("b2b.after", 32'({busy, done}), 32'd0);

        // Leave a non-zero result behind, then reset mid-RUN.
        run_op("pre_reset", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
        a = 16'hFFFF; b = 16'hFFFF; c_in = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_reset.outputs", 32'({busy, done, c_out, ovf, sum}), 32'd0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) dones++;
            tick();
        end
        check("mid_reset.no_done", 32'(dones), 32'd0);
        run_op("restart", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            ref_r = model_add(ra, rb, rc);
            run_op($sformatf("rand%0d", i), ra, rb, rc, ref_r[c_w-1:0],
                   ref_r[c_w]);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks,
                 n_errors);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
